// File: rtl/ram_burst_ctrl_if.sv
// Word-beat command/data bus between the interface FIFOs and the RAM burst controller.
// master drives beats and commands; slave returns read data and status.
interface ram_burst_ctrl_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 14
);
    logic                 ram_beat;
    logic                 ram_aval;
    logic                 ram_wr;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_data_in;
    logic                 ram_ack;
    logic [WORD_SIZE-1:0] ram_data_out;
    logic                 ram_busy;
    logic                 ram_err;

    modport master (
        output ram_beat, ram_aval, ram_wr, ram_addr, ram_data_in,
        input  ram_ack, ram_data_out, ram_busy, ram_err
    );

    modport slave (
        input  ram_beat, ram_aval, ram_wr, ram_addr, ram_data_in,
        output ram_ack, ram_data_out, ram_busy, ram_err
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// RAM-side burst controller: BURST_LEN-word line writes and fixed-latency line reads
// over a word memory; doubles as the synthesizable main-memory model.
module ram_burst_ctrl #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDR_SIZE    = 14,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic           ram_clk,
    input  logic           ram_reset,
    ram_burst_ctrl_if.slave bus
);
    localparam int unsigned BEAT_W    = $clog2(BURST_LEN);
    localparam int unsigned LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned MEM_AW    = ADDR_SIZE + BEAT_W;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [ADDR_SIZE-1:0]  addr_d;
    logic [BEAT_W-1:0]     beat_ctr_q;
    logic [BEAT_W-1:0]     beat_ctr_d;
    logic [LAT_W-1:0]      lat_ctr_q;
    logic [LAT_W-1:0]      lat_ctr_d;
    logic                  ack_q;
    logic                  ack_d;
    logic [WORD_SIZE-1:0]  data_out_q;
    logic [WORD_SIZE-1:0]  data_out_d;
    logic                  busy_q;
    logic                  err_q;
    logic                  err_d;

    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_wa;
    logic [WORD_SIZE-1:0]  mem_rdata;
    logic [WORD_SIZE-1:0]  mem [MEM_DEPTH];

    logic cmd_beat;
    logic data_beat;

    assign cmd_beat  = bus.ram_beat & bus.ram_aval;
    assign data_beat = bus.ram_beat & bus.ram_wr & ~bus.ram_aval;
    assign mem_rdata = mem[{addr_q, beat_ctr_q}];

    // State register
    always_ff @(posedge ram_clk or posedge ram_reset) begin
        if (ram_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_beat) begin
                    if (bus.ram_wr) begin
                        state_d = WR_BURST;
                    end else if (READ_LATENCY == 1) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            WR_BURST: begin
                if (data_beat && (beat_ctr_q == BEAT_LAST)) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_ctr_q == LAT_LAST) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (beat_ctr_q == BEAT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; any beat the current state cannot use sets the sticky error
    always_comb begin
        addr_d     = addr_q;
        beat_ctr_d = beat_ctr_q;
        lat_ctr_d  = lat_ctr_q;
        ack_d      = 1'b0;
        data_out_d = data_out_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_wa     = {addr_q, beat_ctr_q};
        unique case (state_q)
            IDLE: begin
                if (cmd_beat) begin
                    addr_d = bus.ram_addr;
                    if (bus.ram_wr) begin
                        mem_we     = 1'b1;
                        mem_wa     = {bus.ram_addr, BEAT_W'(0)};
                        beat_ctr_d = BEAT_W'(1);
                    end else begin
                        lat_ctr_d  = LAT_W'(1);
                        beat_ctr_d = BEAT_W'(0);
                    end
                end else if (bus.ram_beat) begin
                    err_d = 1'b1;
                end
            end
            WR_BURST: begin
                if (data_beat) begin
                    mem_we     = 1'b1;
                    beat_ctr_d = beat_ctr_q + BEAT_W'(1);
                end else if (bus.ram_beat) begin
                    err_d = 1'b1;
                end
            end
            RD_WAIT: begin
                lat_ctr_d = lat_ctr_q + LAT_W'(1);
                if (lat_ctr_q == LAT_LAST) begin
                    beat_ctr_d = BEAT_W'(0);
                end
                if (bus.ram_beat) begin
                    err_d = 1'b1;
                end
            end
            RD_BURST: begin
                ack_d      = 1'b1;
                data_out_d = mem_rdata;
                beat_ctr_d = beat_ctr_q + BEAT_W'(1);
                if (bus.ram_beat) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge ram_clk or posedge ram_reset) begin
        if (ram_reset) begin
            addr_q     <= '0;
            beat_ctr_q <= '0;
            lat_ctr_q  <= '0;
            ack_q      <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            beat_ctr_q <= beat_ctr_d;
            lat_ctr_q  <= lat_ctr_d;
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
            busy_q     <= (state_d != IDLE);
            err_q      <= err_d;
        end
    end

    // Word memory: never cleared, write suppressed while reset is held
    always_ff @(posedge ram_clk) begin
        if (mem_we && !ram_reset) begin
            mem[mem_wa] <= bus.ram_data_in;
        end
    end

    assign bus.ram_ack      = ack_q;
    assign bus.ram_data_out = data_out_q;
    assign bus.ram_busy     = busy_q;
    assign bus.ram_err      = err_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: three instances (READ_LATENCY 2, 1, 4) share one stimulus stream,
// checked against a word-array memory model and the read timing rule.
module tb_ram_burst_ctrl;
    localparam int unsigned WS = 32;
    localparam int unsigned AS = 14;
    localparam int unsigned BL = 4;
    localparam int          RD_WIN = 10;

    logic          ram_clk;
    logic          ram_reset;
    logic          in_beat;
    logic          in_aval;
    logic          in_wr;
    logic [AS-1:0] in_addr;
    logic [WS-1:0] in_data;
    logic          sweep_en;

    int errors = 0;
    int checks = 0;
    logic exp_err;
    logic [WS-1:0] model [int];
    int lines [$];
    int rl_v [3] = '{2, 1, 4};
    int first_k [3];

    ram_burst_ctrl_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus2 ();
    ram_burst_ctrl_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus1 ();
    ram_burst_ctrl_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus4 ();

    ram_burst_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .BURST_LEN(BL), .READ_LATENCY(2))
        u_dut  (.ram_clk(ram_clk), .ram_reset(ram_reset), .bus(bus2));
    ram_burst_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .BURST_LEN(BL), .READ_LATENCY(1))
        u_dut1 (.ram_clk(ram_clk), .ram_reset(ram_reset), .bus(bus1));
    ram_burst_ctrl #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .BURST_LEN(BL), .READ_LATENCY(4))
        u_dut4 (.ram_clk(ram_clk), .ram_reset(ram_reset), .bus(bus4));

    assign bus2.ram_beat = in_beat;
    assign bus2.ram_aval = in_aval;
    assign bus2.ram_wr = in_wr;
    assign bus2.ram_addr = in_addr;
    assign bus2.ram_data_in = in_data;
    assign bus1.ram_beat = in_beat & sweep_en;
    assign bus1.ram_aval = in_aval;
    assign bus1.ram_wr = in_wr;
    assign bus1.ram_addr = in_addr;
    assign bus1.ram_data_in = in_data;
    assign bus4.ram_beat = in_beat & sweep_en;
    assign bus4.ram_aval = in_aval;
    assign bus4.ram_wr = in_wr;
    assign bus4.ram_addr = in_addr;
    assign bus4.ram_data_in = in_data;

    logic          ack_v [3];
    logic [WS-1:0] dat_v [3];
    assign ack_v[0] = bus2.ram_ack;
    assign ack_v[1] = bus1.ram_ack;
    assign ack_v[2] = bus4.ram_ack;
    assign dat_v[0] = bus2.ram_data_out;
    assign dat_v[1] = bus1.ram_data_out;
    assign dat_v[2] = bus4.ram_data_out;

    initial begin
        ram_clk = 1'b0;
        forever #5 ram_clk = ~ram_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic a, input logic w, input logic [AS-1:0] ad, input logic [WS-1:0] d);
        in_beat = 1'b1;
        in_aval = a;
        in_wr   = w;
        in_addr = ad;
        in_data = d;
    endtask

    task automatic step();
        @(posedge ram_clk);
        #1;
        in_beat = 1'b0;
        in_aval = 1'b0;
        in_wr   = 1'b0;
    endtask

    // Full line write with an optional stall of gap_len idle cycles before beat gap_at
    task automatic do_write(input logic [AS-1:0] a, input logic [BL*WS-1:0] words,
                            input int gap_at, input int gap_len, input string nm);
        for (int i = 0; i < int'(BL); i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step();
                    checks++;
                    if (bus2.ram_busy !== 1'b1)
                        $display("FAIL %s stall busy g=%0d got=%b exp=1", nm, g, bus2.ram_busy);
                    if (bus2.ram_busy !== 1'b1) errors++;
                end
            end
            set_in(i == 0, 1'b1, a, words[i*WS +: WS]);
            step();
            model[int'(a) * BL + i] = words[i*WS +: WS];
            checks++;
            if (bus2.ram_busy !== logic'(i != int'(BL) - 1)) begin
                errors++;
                $display("FAIL %s busy beat=%0d got=%b exp=%b", nm, i, bus2.ram_busy, i != int'(BL) - 1);
            end
        end
        lines.push_back(int'(a));
    endtask

    // Line read; optionally injects a write-command beat sampled on edge inj_k after the command
    task automatic do_read(input logic [AS-1:0] a, input int inj_k, input string nm);
        logic exp_ack;
        logic [WS-1:0] exp_w;
        int base;
        base = int'(a) * BL;
        for (int d = 0; d < 3; d++) first_k[d] = 0;
        set_in(1'b1, 1'b0, a, WS'($urandom));
        step();
        for (int k = 1; k <= RD_WIN; k++) begin
            if (k == inj_k) set_in(1'b1, 1'b1, AS'($urandom), WS'($urandom));
            step();
            for (int d = 0; d < 3; d++) begin
                if (d > 0 && !sweep_en) continue;
                exp_ack = (k >= rl_v[d]) && (k < rl_v[d] + int'(BL));
                checks++;
                if (ack_v[d] !== exp_ack) begin
                    errors++;
                    $display("FAIL %s ack rl=%0d edge=%0d got=%b exp=%b", nm, rl_v[d], k, ack_v[d], exp_ack);
                end
                if (ack_v[d] === 1'b1 && first_k[d] == 0) first_k[d] = k;
                if (exp_ack) begin
                    exp_w = model[base + k - rl_v[d]];
                    checks++;
                    if (dat_v[d] !== exp_w) begin
                        errors++;
                        $display("FAIL %s data rl=%0d edge=%0d got=%h exp=%h", nm, rl_v[d], k, dat_v[d], exp_w);
                    end
                end else if (d == 0 && k >= rl_v[d] + int'(BL)) begin
                    exp_w = model[base + int'(BL) - 1];
                    checks++;
                    if (dat_v[d] !== exp_w) begin
                        errors++;
                        $display("FAIL %s data_hold edge=%0d got=%h exp=%h", nm, k, dat_v[d], exp_w);
                    end
                end
            end
        end
        checks++;
        if (bus2.ram_busy !== 1'b0 || bus2.ram_err !== exp_err) begin
            errors++;
            $display("FAIL %s end busy/err got=%b/%b exp=0/%b", nm, bus2.ram_busy, bus2.ram_err, exp_err);
        end
    endtask

    task automatic do_reset(input string nm);
        ram_reset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack_v[d] !== 1'b0 || dat_v[d] !== '0) begin
                errors++;
                $display("FAIL %s ack/data dut=%0d got=%b/%h exp=0/0", nm, d, ack_v[d], dat_v[d]);
            end
        end
        checks++;
        if (bus2.ram_busy !== 1'b0 || bus2.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/err got=%b/%b exp=0/0", nm, bus2.ram_busy, bus2.ram_err);
        end
        @(posedge ram_clk);
        #1;
        ram_reset = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        in_beat = 1'b0; in_aval = 1'b0; in_wr = 1'b0; in_addr = '0; in_data = '0;
        sweep_en = 1'b1;
        ram_reset = 1'b1;
        repeat (2) @(posedge ram_clk);
        #1;
        do_reset("reset");
    endtask

    task automatic test_write_line();
        do_write(AS'(5), {WS'(44), WS'(33), WS'(22), WS'(11)}, -1, 0, "write_0005");
    endtask

    task automatic test_read_line();
        do_read(AS'(5), -1, "read_0005");
        checks++;
        if (first_k[0] != 2) begin
            errors++;
            $display("FAIL read_0005 first_ack got=%0d exp=2", first_k[0]);
        end
    endtask

    task automatic test_stall_write();
        do_write(AS'(16'h3FFF), {WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom)}, 2, 2, "stall_3fff");
        do_read(AS'(16'h3FFF), -1, "read_3fff");
    endtask

    task automatic test_drop_during_read();
        do_reset("reset_drop");
        sweep_en = 1'b0;
        exp_err = 1'b1;
        do_read(AS'(5), 3, "drop_in_rd_burst");
        sweep_en = 1'b1;
    endtask

    task automatic test_stray_beat();
        do_reset("reset_stray");
        sweep_en = 1'b0;
        set_in(1'b0, 1'($urandom), AS'($urandom), WS'($urandom));
        step();
        exp_err = 1'b1;
        checks++;
        if (bus2.ram_busy !== 1'b0 || bus2.ram_err !== 1'b1) begin
            errors++;
            $display("FAIL stray busy/err got=%b/%b exp=0/1", bus2.ram_busy, bus2.ram_err);
        end
        sweep_en = 1'b1;
        do_read(AS'(5), -1, "read_after_stray");
    endtask

    task automatic test_reset_mid_burst();
        logic [WS-1:0] w0, w1;
        logic [AS-1:0] a;
        a = AS'(16'h0123);
        do_reset("reset_pre_mid");
        do_write(a, {WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom)}, -1, 0, "mid_old");
        w0 = WS'($urandom);
        w1 = WS'($urandom);
        set_in(1'b1, 1'b1, a, w0);
        step();
        set_in(1'b0, 1'b1, a, w1);
        step();
        model[int'(a) * BL] = w0;
        model[int'(a) * BL + 1] = w1;
        checks++;
        if (bus2.ram_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst busy got=%b exp=1", bus2.ram_busy);
        end
        do_reset("reset_mid_burst");
        do_read(a, -1, "read_after_mid_reset");
    endtask

    task automatic test_back_to_back();
        logic [AS-1:0] a;
        do_reset("reset_b2b");
        sweep_en = 1'b0;
        exp_err = 1'b1;
        do_read(AS'(16'h3FFF), 2 + int'(BL) - 1, "b2b_cmd_on_last_edge");
        sweep_en = 1'b1;
        a = AS'(16'h2A5A);
        do_write(a, {WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom)}, -1, 0, "b2b_write");
        do_read(a, -1, "b2b_read");
    endtask

    task automatic test_latency_sweep();
        logic [AS-1:0] a;
        a = AS'($urandom);
        do_write(a, {WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom)}, -1, 0, "sweep_write");
        do_read(a, -1, "sweep_read");
        checks++;
        if (first_k[1] != 1) begin
            errors++;
            $display("FAIL sweep rl1 first_ack got=%0d exp=1", first_k[1]);
        end
        checks++;
        if (first_k[2] != 4) begin
            errors++;
            $display("FAIL sweep rl4 first_ack got=%0d exp=4", first_k[2]);
        end
    endtask

    task automatic test_random();
        logic [AS-1:0] a;
        for (int n = 0; n < 16; n++) begin
            if (lines.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = AS'($urandom);
                do_write(a, {WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom)},
                         int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), "rand_write");
            end else begin
                a = AS'(lines[$urandom_range(0, lines.size() - 1)]);
                do_read(a, -1, "rand_read");
            end
        end
    endtask

    initial begin
        exp_err = 1'b0;
        test_reset();
        test_write_line();
        test_read_line();
        test_stall_write();
        test_drop_during_read();
        test_stray_beat();
        test_reset_mid_burst();
        test_back_to_back();
        test_latency_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
